// File: rtl/rw_init_pkg.sv
// Shared constants for the read/write en/rdy initiator: default widths,
// command opcodes and the supported read-latency ceiling.
package rw_init_pkg;
    localparam int   ADDR_W_DEF = 3;
    localparam int   DATA_W_DEF = 1;
    localparam logic OP_READ    = 1'b0;
    localparam logic OP_WRITE   = 1'b1;
    localparam int   RD_LAT_MAX = 7;
endpackage

// File: rtl/rw_rsp_fifo.sv
// Synchronous response FIFO with an exposed occupancy count; pointers wrap
// modulo the power-of-two depth.
module rw_rsp_fifo
    import rw_init_pkg::*;
#(
    parameter int  DATA_W    = DATA_W_DEF,
    parameter int  RSP_DEPTH = 4,
    localparam int CW        = $clog2(RSP_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count
);
    localparam int            PW   = $clog2(RSP_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(RSP_DEPTH);

    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(push && !pop && count == FULL));
endmodule

// File: rtl/rw_initiator.sv
// Requester for the en/rdy read/write target bus: one-entry command hold,
// credit-limited read issue, fixed-latency capture and in-order responses.
module rw_initiator
    import rw_init_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic              read_rdy,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic              busy
);
    localparam int            CW      = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RSP_DEPTH);

    logic              hold_valid;
    logic              hold_write;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;
    logic              issue;
    logic              credit_ok;
    logic              cap_push;
    logic [DATA_W-1:0] cap_data;
    logic [CW-1:0]     rsp_count;
    logic [CW-1:0]     inflight;
    logic              rsp_pop;

    // A read may only go out if its response already has a FIFO slot reserved.
    assign credit_ok = ({1'b0, rsp_count} + {1'b0, inflight}) < DEPTH_C;
    assign write_en  = hold_valid & (hold_write == OP_WRITE) & write_rdy;
    assign read_en   = hold_valid & (hold_write == OP_READ) & read_rdy & credit_ok;
    assign issue     = read_en | write_en;
    assign cmd_ready = !hold_valid | issue;

    assign read_address  = hold_addr;
    assign write_address = hold_addr;
    assign write_data    = hold_wdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_valid <= 1'b0;
            hold_write <= OP_READ;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (cmd_valid && cmd_ready) begin
            hold_valid <= 1'b1;
            hold_write <= cmd_write;
            hold_addr  <= cmd_addr;
            hold_wdata <= cmd_wdata;
        end else if (issue) begin
            hold_valid <= 1'b0;
        end
    end

    if (RD_LAT == 0) begin : g_lat0
        assign cap_push = read_en;
        assign cap_data = read_data;
        assign inflight = '0;
    end else begin : g_lat
        logic [RD_LAT-1:0] flags;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) flags <= '0;
            else     flags <= (flags << 1) | RD_LAT'(read_en);
        end

        always_comb begin
            inflight = '0;
            for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(flags[i]);
        end

        assign cap_push = flags[RD_LAT-1];
        assign cap_data = read_data;
    end

    assign rsp_valid = (rsp_count != '0);
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign busy      = hold_valid | (inflight != '0) | (rsp_count != '0);

    rw_rsp_fifo #(
        .DATA_W   (DATA_W),
        .RSP_DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (cap_push),
        .push_data(cap_data),
        .pop      (rsp_pop),
        .head_data(rsp_data),
        .count    (rsp_count)
    );
endmodule

// File: tb/tb_rw_initiator.sv
// Directed bench for rw_initiator against a latency-2 memory-model target.
module tb_rw_initiator;
    logic       CLK = 1'b0;
    logic       RST;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [2:0] cmd_addr;
    logic       cmd_wdata;
    logic       rsp_valid, rsp_ready, rsp_data;
    logic [2:0] read_address, write_address;
    logic       read_en, read_rdy, read_data;
    logic       write_data, write_en, write_rdy;
    logic       busy;

    int n_err = 0;
    int n_chk = 0;

    always #5 CLK = ~CLK;

    rw_initiator #(
        .ADDR_W(3), .DATA_W(1), .RD_LAT(2), .RSP_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .read_address(read_address), .read_en(read_en), .read_rdy(read_rdy),
        .read_data(read_data),
        .write_address(write_address), .write_data(write_data),
        .write_en(write_en), .write_rdy(write_rdy), .busy(busy)
    );

    // Target model: 8x1 memory, read data valid two cycles after read_en.
    logic mem [8];
    logic rd_p1 = 1'b0;
    logic rd_p2 = 1'b0;
    always @(posedge CLK) begin
        if (write_en) mem[write_address] <= write_data;
        rd_p1 <= read_en ? mem[read_address] : 1'b0;
        rd_p2 <= rd_p1;
    end
    assign read_data = rd_p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic w, input logic [2:0] a, input logic d);
        logic acc;
        logic done;
        done      = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            acc = cmd_ready;
            tick();
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        chk("send_accept", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic got [6];
    int   k, nrd, nrsp;
    logic acc;
    logic seen;

    initial begin
        RST = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = 1'b0;
        rsp_ready = 1'b1; read_rdy = 1'b1; write_rdy = 1'b1;
        tick();
        @(negedge CLK);
        chk("rst_read_en", read_en, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_addr", {29'd0, read_address}, 0);
        chk("rst_wdata", write_data, 0);
        tick();
        RST = 1'b0;

        // Single write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd5; cmd_wdata = 1'b1;
        @(negedge CLK);
        chk("w_cmd_ready", cmd_ready, 1);
        chk("w_no_early_en", write_en, 0);
        tick();
        cmd_valid = 1'b0;
        @(negedge CLK);
        chk("w_en", write_en, 1);
        chk("w_addr", {29'd0, write_address}, 5);
        chk("w_data", write_data, 1);
        chk("w_busy", busy, 1);
        tick();
        @(negedge CLK);
        chk("w_en_once", write_en, 0);
        chk("w_no_rsp", rsp_valid, 0);
        chk("w_idle", busy, 0);
        tick();

        // Single read of address 3 holding 1
        send(1'b1, 3'd3, 1'b1);
        tick(); tick();
        rsp_ready = 1'b0;
        send(1'b0, 3'd3, 1'b0);
        @(negedge CLK);
        chk("r_en", read_en, 1);
        chk("r_addr", {29'd0, read_address}, 3);
        tick();
        @(negedge CLK);
        chk("r_en_once", read_en, 0);
        tick();
        @(negedge CLK);
        chk("r_rsp_not_yet", rsp_valid, 0);
        tick();
        @(negedge CLK);
        chk("r_rsp_valid", rsp_valid, 1);
        chk("r_rsp_data", rsp_data, 1);
        rsp_ready = 1'b1;
        tick();
        @(negedge CLK);
        chk("r_rsp_popped", rsp_valid, 0);
        chk("r_idle", busy, 0);
        tick();

        // Write held while write_rdy is low
        write_rdy = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 1'b0;
        @(negedge CLK);
        chk("wr_stall_accept", cmd_ready, 1);
        tick();
        cmd_addr = 3'd6; cmd_wdata = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("wr_stall_en", write_en, 0);
            chk("wr_stall_ready", cmd_ready, 0);
            tick();
        end
        write_rdy = 1'b1;
        @(negedge CLK);
        chk("wr_release_en", write_en, 1);
        chk("wr_release_addr", {29'd0, write_address}, 2);
        chk("wr_release_data", write_data, 0);
        chk("wr_release_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        @(negedge CLK);
        chk("wr_second_en", write_en, 1);
        chk("wr_second_addr", {29'd0, write_address}, 6);
        chk("wr_second_data", write_data, 1);
        tick();

        // Credit limit: six reads with responses blocked
        send(1'b1, 3'd0, 1'b1);
        send(1'b1, 3'd1, 1'b0);
        send(1'b1, 3'd2, 1'b1);
        send(1'b1, 3'd3, 1'b1);
        send(1'b1, 3'd4, 1'b0);
        send(1'b1, 3'd5, 1'b1);
        tick(); tick();
        rsp_ready = 1'b0;
        k = 0; nrd = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = (k < 6); cmd_write = 1'b0; cmd_addr = 3'(k);
            @(negedge CLK);
            if (read_en) nrd++;
            acc = cmd_valid & cmd_ready;
            tick();
            if (acc) k++;
        end
        chk("cr_reads_issued", nrd, 4);
        chk("cr_cmds_taken", k, 5);
        @(negedge CLK);
        chk("cr_fifth_stalled", read_en, 0);
        chk("cr_cmd_blocked", cmd_ready, 0);
        tick();
        rsp_ready = 1'b1;
        nrd = 0; nrsp = 0;
        for (int c = 0; c < 40 && nrsp < 6; c++) begin
            cmd_valid = (k < 6); cmd_write = 1'b0; cmd_addr = 3'(k);
            @(negedge CLK);
            if (read_en) nrd++;
            if (rsp_valid && rsp_ready) begin
                got[nrsp] = rsp_data;
                nrsp++;
            end
            acc = cmd_valid & cmd_ready;
            tick();
            if (acc) k++;
        end
        cmd_valid = 1'b0;
        chk("cr_rsp_total", nrsp, 6);
        chk("cr_late_reads", nrd, 2);
        chk("cr_rsp0", got[0], 1);
        chk("cr_rsp1", got[1], 0);
        chk("cr_rsp2", got[2], 1);
        chk("cr_rsp3", got[3], 1);
        chk("cr_rsp4", got[4], 0);
        chk("cr_rsp5", got[5], 1);
        tick(); tick();

        // Reset with two reads in flight and one response queued
        rsp_ready = 1'b0;
        send(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd0;
        tick();
        cmd_addr = 3'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mr_busy_before", busy, 1);
        chk("mr_rsp_before", rsp_valid, 1);
        RST = 1'b1;
        #1;
        chk("mr_read_en", read_en, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cmd_ready", cmd_ready, 1);
        tick();
        RST = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("mr_no_late_rsp", rsp_valid, 0);
            tick();
        end
        chk("mr_idle_after", busy, 0);

        // Write then read of the same address back to back
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 1'b1;
        @(negedge CLK);
        chk("wr_rd_accept_w", cmd_ready, 1);
        tick();
        cmd_write = 1'b0; cmd_wdata = 1'b0;
        @(negedge CLK);
        chk("wr_rd_write_en", write_en, 1);
        chk("wr_rd_accept_r", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        @(negedge CLK);
        chk("wr_rd_read_en", read_en, 1);
        chk("wr_rd_read_addr", {29'd0, read_address}, 2);
        chk("wr_rd_no_write", write_en, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            @(negedge CLK);
            seen = rsp_valid;
        end
        chk("wr_rd_rsp_seen", seen, 1);
        chk("wr_rd_rsp_data", rsp_data, 1);
        rsp_ready = 1'b1;
        tick();
        @(negedge CLK);
        chk("wr_rd_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
